// File: rtl/wdt_sched_pkg.sv
// Shared encodings and field layout for the watchdog scheduler.
// Included by the interface, the prescaler and the FSM top.
package wdt_sched_pkg;

    localparam int WDT_CFG_W   = 8;
    localparam int WDT_T_W     = 7;
    localparam int WDT_CNT_W   = 8;
    localparam int WDT_STATE_W = 2;

    localparam int WDT_CFG_EN    = 7;
    localparam int WDT_CFG_T_MSB = 6;
    localparam int WDT_CFG_T_LSB = 0;

    typedef enum logic [WDT_STATE_W-1:0] {
        WDT_IDLE    = 2'd0,
        WDT_ARMED   = 2'd1,
        WDT_TRIPPED = 2'd2
    } wdt_state_e;

    typedef struct packed {
        logic               en;
        logic [WDT_T_W-1:0] t;
    } wdt_cfg_t;

    function automatic wdt_cfg_t wdt_cfg_decode(input logic [WDT_CFG_W-1:0] data);
        wdt_cfg_t c;
        c.en = data[WDT_CFG_EN];
        c.t  = data[WDT_CFG_T_MSB:WDT_CFG_T_LSB];
        return c;
    endfunction

    // A write only arms the watchdog when it is enabled with a non-zero timeout.
    function automatic logic wdt_cfg_arms(input wdt_cfg_t c);
        return c.en && (c.t != '0);
    endfunction

endpackage

// File: rtl/wdt_sched_if.sv
// Host-side strobes and watchdog status bundled as one port.
// master = register decode / bench, slave = wdt_sched.
interface wdt_sched_if;
    import wdt_sched_pkg::*;

    logic                   cfg_we;
    logic [WDT_CFG_W-1:0]   cfg_data;
    logic                   kick;
    logic                   clr_fault;

    logic                   out_enable;
    logic                   fault;
    logic                   warn;
    logic [WDT_STATE_W-1:0] state;
    logic [WDT_T_W-1:0]     remaining;
    logic [WDT_CNT_W-1:0]   trip_count;

    modport master (
        output cfg_we, cfg_data, kick, clr_fault,
        input  out_enable, fault, warn, state, remaining, trip_count
    );

    modport slave (
        input  cfg_we, cfg_data, kick, clr_fault,
        output out_enable, fault, warn, state, remaining, trip_count
    );

endinterface

// File: rtl/wdt_prescale.sv
// Free-running timebase: one tick every TICK_DIV clocks.
// A synchronous clear restarts the period so a kick or load gets a full tick.
module wdt_prescale #(
    parameter int TICK_DIV = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (clr || tick) begin
            pre_d = '0;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/wdt_sched.sv
// Watchdog FSM: arms on config write, reloads on kick, trips on countdown expiry
// and latches the fault until acknowledged. Outputs decode from registers only.
module wdt_sched
    import wdt_sched_pkg::*;
#(
    parameter int TICK_DIV   = 4096,
    parameter int WARN_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    wdt_sched_if.slave  bus
);

    localparam logic [WDT_T_W-1:0] WARN_LIM = WDT_T_W'(WARN_TICKS);

    wdt_state_e           state_q,      state_d;
    logic [WDT_T_W-1:0]   timeout_q,    timeout_d;
    logic [WDT_T_W-1:0]   remaining_q,  remaining_d;
    logic [WDT_CNT_W-1:0] trip_count_q, trip_count_d;

    logic     pre_clr;
    logic     tick;
    wdt_cfg_t cfg;

    assign cfg = wdt_cfg_decode(bus.cfg_data);

    wdt_prescale #(
        .TICK_DIV (TICK_DIV)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d      = state_q;
        timeout_d    = timeout_q;
        remaining_d  = remaining_q;
        trip_count_d = trip_count_q;
        pre_clr      = 1'b0;

        case (state_q)
            WDT_IDLE: begin
                if (bus.cfg_we) begin
                    timeout_d = cfg.t;
                    if (wdt_cfg_arms(cfg)) begin
                        remaining_d = cfg.t;
                        pre_clr     = 1'b1;
                        state_d     = WDT_ARMED;
                    end
                end
            end

            WDT_ARMED: begin
                // Config beats kick beats tick; a kick on a tick edge swallows the decrement.
                if (bus.cfg_we) begin
                    timeout_d = cfg.t;
                    if (wdt_cfg_arms(cfg)) begin
                        remaining_d = cfg.t;
                        pre_clr     = 1'b1;
                    end else begin
                        state_d = WDT_IDLE;
                    end
                end else if (bus.kick) begin
                    remaining_d = timeout_q;
                    pre_clr     = 1'b1;
                end else if (tick) begin
                    if (remaining_q > 7'd1) begin
                        remaining_d = remaining_q - 7'd1;
                    end else begin
                        remaining_d = '0;
                        state_d     = WDT_TRIPPED;
                        if (trip_count_q != '1) begin
                            trip_count_d = trip_count_q + 8'd1;
                        end
                    end
                end
            end

            WDT_TRIPPED: begin
                if (bus.clr_fault) begin
                    state_d     = WDT_IDLE;
                    remaining_d = '0;
                end
            end

            default: begin
                state_d = WDT_TRIPPED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WDT_IDLE;
            timeout_q    <= '0;
            remaining_q  <= '0;
            trip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            timeout_q    <= timeout_d;
            remaining_q  <= remaining_d;
            trip_count_q <= trip_count_d;
        end
    end

    assign bus.out_enable = (state_q != WDT_TRIPPED);
    assign bus.fault      = (state_q == WDT_TRIPPED);
    assign bus.warn       = (state_q == WDT_ARMED) && (remaining_q <= WARN_LIM);
    assign bus.state      = state_q;
    assign bus.remaining  = remaining_q;
    assign bus.trip_count = trip_count_q;

endmodule

// File: tb/tb_wdt_sched.sv
// Directed bench for wdt_sched (TICK_DIV=4, WARN_TICKS=1): stimulus queues the
// expected status per clock edge, a negedge monitor pops and compares.
module tb_wdt_sched;
    import wdt_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wdt_sched_if bus ();

    wdt_sched #(
        .TICK_DIV   (4),
        .WARN_TICKS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string name;
        int    at;
        int    st;
        int    rem;
        int    tc;
        int    pre;
        bit    chk_rem;
        bit    chk_pre;
    } exp_t;

    exp_t sb[$];

    int edge_cnt = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int tc_exp   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic expect_at(input string name, input int at, input int st, input int rem,
                             input bit chk_rem, input int pre, input bit chk_pre);
        exp_t e;
        e.name    = name;
        e.at      = at;
        e.st      = st;
        e.rem     = rem;
        e.tc      = tc_exp;
        e.pre     = pre;
        e.chk_rem = chk_rem;
        e.chk_pre = chk_pre;
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [1:0] a_pre;
        logic       f_exp, oe_exp, w_exp;
        bit         ok;
        a_pre  = dut.u_pre.pre_q;
        f_exp  = (e.st == 2);
        oe_exp = (e.st != 2);
        w_exp  = (e.st == 1) && (e.rem <= 1);
        ok = (e.at == edge_cnt)
          && (int'(bus.state) == e.st)
          && (!e.chk_rem || int'(bus.remaining) == e.rem)
          && (int'(bus.trip_count) == e.tc)
          && (!e.chk_pre || int'(a_pre) == e.pre)
          && (bus.fault === f_exp) && (bus.out_enable === oe_exp) && (bus.warn === w_exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @edge %0d (due %0d): got st=%0d rem=%0d tc=%0d pre=%0d f=%b oe=%b w=%b; want st=%0d rem=%0d%s tc=%0d pre=%0d%s f=%b oe=%b w=%b",
                     e.name, edge_cnt, e.at, bus.state, bus.remaining, bus.trip_count, a_pre,
                     bus.fault, bus.out_enable, bus.warn, e.st, e.rem, e.chk_rem ? "" : "(any)",
                     e.tc, e.pre, e.chk_pre ? "" : "(any)", f_exp, oe_exp, w_exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
            check(sb.pop_front());
        end
    end

    // Presents one cycle of inputs; returns the edge index that sampled them.
    task automatic drive(input logic we, input logic [7:0] data, input logic k,
                         input logic c, input logic r, output int e);
        bus.cfg_we    = we;
        bus.cfg_data  = data;
        bus.kick      = k;
        bus.clr_fault = c;
        rst           = r;
        @(posedge clk);
        #1;
        bus.cfg_we    = 1'b0;
        bus.cfg_data  = 8'h00;
        bus.kick      = 1'b0;
        bus.clr_fault = 1'b0;
        rst           = 1'b0;
        e = edge_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: edge %0d reached, want run complete", edge_cnt);
        $fatal(1, "bench timed out");
    end

    initial begin
        int e, e0, e1, ec, k;
        bus.cfg_we    = 1'b0;
        bus.cfg_data  = 8'h00;
        bus.kick      = 1'b0;
        bus.clr_fault = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        drive(0, 8'h00, 0, 0, 1, e);
        expect_at("reset", e, 0, 0, 1, 0, 1);

        // Arm with T=3 and let it trip at E0+12
        drive(1, 8'h83, 0, 0, 0, e0);
        expect_at("arm",       e0,      1, 3, 1, 0, 1);
        expect_at("pre3",      e0 + 3,  1, 3, 1, 3, 1);
        expect_at("dec_to2",   e0 + 4,  1, 2, 1, 0, 1);
        expect_at("dec_warn",  e0 + 8,  1, 1, 1, 0, 1);
        expect_at("pre_trip",  e0 + 11, 1, 1, 1, 3, 1);
        tc_exp = 1;
        expect_at("trip",      e0 + 12, 2, 0, 1, 0, 1);
        idle(12);

        // TRIPPED ignores kick and config; clr_fault wins over kick
        drive(0, 8'h00, 1, 0, 0, e);
        expect_at("trip_kick", e, 2, 0, 1, 0, 0);
        drive(1, 8'h85, 0, 0, 0, e);
        expect_at("trip_cfg", e, 2, 0, 1, 0, 0);
        drive(0, 8'h00, 1, 1, 0, e);
        expect_at("clr_kick", e, 0, 0, 1, 0, 0);
        drive(0, 8'h00, 1, 0, 0, e);
        expect_at("idle_kick", e, 0, 0, 1, 0, 0);
        expect_at("idle_hold", e + 3, 0, 0, 1, 0, 0);
        idle(3);

        // Disarm paths
        drive(1, 8'h80, 0, 0, 0, e);
        expect_at("cfg_t0_idle", e, 0, 0, 1, 0, 0);
        drive(1, 8'h05, 0, 0, 0, e);
        expect_at("cfg_dis_idle", e, 0, 0, 1, 0, 0);
        drive(1, 8'h84, 0, 0, 0, e1);
        expect_at("arm4", e1, 1, 4, 1, 0, 1);
        idle(2);
        drive(1, 8'h05, 0, 0, 0, e);
        expect_at("disarm",     e,       0, 0, 0, 0, 0);
        expect_at("disarm_50",  e + 50,  0, 0, 0, 0, 0);
        expect_at("disarm_100", e + 100, 0, 0, 0, 0, 0);
        idle(100);

        // Reload while ARMED
        drive(1, 8'h83, 0, 0, 0, e);
        expect_at("arm3b",  e,     1, 3, 1, 0, 1);
        expect_at("dec_b",  e + 4, 1, 2, 1, 0, 1);
        idle(5);
        drive(1, 8'h8A, 0, 0, 0, e);
        expect_at("reload",     e,     1, 10, 1, 0, 1);
        expect_at("reload_dec", e + 4, 1, 9,  1, 0, 1);
        idle(4);

        // Kick in the same cycle as a tick
        drive(1, 8'h00, 0, 0, 0, e);
        expect_at("disarm2", e, 0, 0, 0, 0, 0);
        drive(1, 8'h83, 0, 0, 0, ec);
        expect_at("arm_c",  ec,     1, 3, 1, 0, 1);
        expect_at("c_dec",  ec + 4, 1, 2, 1, 0, 1);
        expect_at("c_pre3", ec + 7, 1, 2, 1, 3, 1);
        idle(7);
        drive(0, 8'h00, 1, 0, 0, k);
        expect_at("collide", k, 1, 3, 1, 0, 1);

        // Regular servicing: kick every 8 cycles for 400 cycles
        for (int i = 0; i < 50; i++) begin
            for (int j = 1; j < 8; j++) begin
                expect_at("svc", k + j, 1, (j < 4) ? 3 : 2, 1, j % 4, 1);
            end
            idle(7);
            drive(0, 8'h00, 1, 0, 0, k);
            expect_at("svc_kick", k, 1, 3, 1, 0, 1);
        end
        drive(1, 8'h00, 0, 0, 0, e);
        expect_at("svc_disarm", e, 0, 0, 0, 0, 0);

        // Reset with remaining==1: no trip, counters cleared
        drive(1, 8'h82, 0, 0, 0, e);
        expect_at("arm2",  e,     1, 2, 1, 0, 1);
        expect_at("r_dec", e + 4, 1, 1, 1, 0, 1);
        idle(5);
        drive(0, 8'h00, 0, 0, 1, e);
        tc_exp = 0;
        expect_at("rst_mid",     e,      0, 0, 1, 0, 1);
        expect_at("rst_no_trip", e + 10, 0, 0, 1, 0, 0);
        idle(10);

        // Trip counter saturation
        for (int i = 0; i < 260; i++) begin
            drive(1, 8'h81, 0, 0, 0, e);
            tc_exp = (tc_exp < 255) ? tc_exp + 1 : 255;
            expect_at("sat_trip", e + 4, 2, 0, 1, 0, 0);
            idle(4);
            drive(0, 8'h00, 0, 1, 0, e);
            expect_at("sat_clr", e, 0, 0, 1, 0, 0);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #6;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wdt_sched.md
# wdt_sched

Watchdog scheduler for the pluto_servo firmware. It arms, services and trips the safety watchdog that gates the PWM/servo outputs. It also owns the timebase prescaler, the programmable timeout and the latched fault. The block sits between the EPP register decode, which supplies `cfg_we`, `kick` and `clr_fault`, and the output stage, which uses `out_enable` to force all drives inactive.

## Interface
- `TICK_DIV`, 4096: clocks per watchdog tick; must be ≥2; the prescaler is `$clog2(TICK_DIV)` bits wide.
- `WARN_TICKS`, 8: `warn` asserts when `remaining ≤ WARN_TICKS` in ARMED.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  one-cycle config write strobe.
- `cfg_data`  in  8  bit7 is enable; bits 6:0 are timeout T in ticks.
- `kick`  in  1  one-cycle service strobe from a valid host write.
- `clr_fault`  in  1  one-cycle fault acknowledge.
- `out_enable`  out  1  1 means the output stage may drive.
- `fault`  out  1  latched trip indication.
- `warn`  out  1  countdown is near expiry.
- `state`  out  2  IDLE=0, ARMED=1, TRIPPED=2.
- `remaining`  out  7  ticks left before trip.
- `trip_count`  out  8  saturating count of trips.

## Operation
- **Registers:**
  - `state`.
  - `timeout` (7b).
  - `remaining` (7b).
  - prescaler `pre`.
  - `trip_count`.
- **Reset values:** state IDLE, timeout 0, remaining 0, pre 0, trip_count 0. Resulting outputs: out_enable 1, fault 0, warn 0.
- **Tick:** `tick = (pre == TICK_DIV-1)` is combinational. `pre` is free-running and wraps to 0. `kick` in ARMED, and any write that loads the countdown, set `pre <= 0`.
- **IDLE:**
  - `cfg_we` with bit7=1 and T≠0: `timeout <= T`, `remaining <= T`, `pre <= 0`, go to ARMED.
  - `cfg_we` with any other value: `timeout <= T`, stay IDLE.
  - `kick` and `clr_fault` are ignored.
- **ARMED:**
  - Priority, highest first: `cfg_we`, then `kick`, then `tick`.
  - `cfg_we` with bit7=0 or T=0: go to IDLE.
  - `cfg_we` with bit7=1 and T≠0: reload `timeout`, `remaining <= T`, `pre <= 0`.
  - `kick`: `remaining <= timeout`, `pre <= 0`.
  - `tick` with remaining>1: decrement `remaining`.
  - `tick` with remaining==1: `remaining <= 0`, go to TRIPPED, `trip_count` +1 (saturates at 255).
- **TRIPPED:**
  - `clr_fault`: go to IDLE, `remaining <= 0`.
  - `cfg_we` and `kick` are ignored; `clr_fault` wins on simultaneous events.
  - Leaving TRIPPED always passes through IDLE; re-arm requires a fresh `cfg_we`.
- **Outputs:**
  - `out_enable = (state != TRIPPED)`.
  - `fault = (state == TRIPPED)`.
  - `warn = (state == ARMED) && (remaining ≤ WARN_TICKS)`.
  - All outputs decode directly from registers, so there is no combinational path from inputs.
- An illegal state encoding (3) recovers to TRIPPED on the next edge (fail safe).

## Timing
- All state changes take effect at the rising `clk` edge that samples the strobe. Outputs reflect them in the following cycle.
- **Trip latency:** let kick or arming be sampled at edge E0 with T loaded. Decrements occur at E0+k·TICK_DIV, and `fault` rises / `out_enable` falls at edge E0+T·TICK_DIV exactly.
- **Kick and tick in the same cycle:** the kick wins. `remaining = timeout`, with no decrement.
- **Strobe width:** strobes are single-cycle. A held strobe acts again every cycle: a held `kick` holds the countdown, and a held `clr_fault` holds IDLE.
- **`rst` mid-countdown:** all registers take reset values at that edge, with no trip and no trip_count change.

## Structure
- The shared include/package holds:
  - the state encodings `WDT_IDLE`, `WDT_ARMED`, `WDT_TRIPPED`;
  - the `cfg_data` field positions (`WDT_CFG_EN` = bit 7, `WDT_CFG_T` = bits 6:0);
  - the width constants.
- One sub-module, `wdt_prescale`: the `TICK_DIV` counter with a synchronous clear input and a `tick` output.
- The FSM, countdown and trip counter stay in `wdt_sched`.
- Expected RTL size is about 150–250 lines.

## Test plan
All scenarios use `TICK_DIV=4` and `WARN_TICKS=1`.
- **Arm and trip:** `rst`, then `cfg_we` with 0x83 at E0 → state 1 and remaining 3. Remaining goes 2 @E0+4, 1 @E0+8 (warn=1). At E0+12: fault=1, out_enable=0, state=2, trip_count=1.
- **Regular servicing:** after arming with 0x83, kick every 8 cycles for 400 cycles → fault stays 0 and remaining never drops below 2.
- **Kick/tick collision:** assert `kick` in the cycle where pre==3 with remaining==2 → next cycle remaining=3 and pre=0.
- **TRIPPED handling:**
  - `kick` and `cfg_we` 0x85 → no change.
  - `clr_fault` with `kick` in the same cycle → state 0, fault 0, out_enable 1.
  - Any following `kick` is ignored until `cfg_we` is seen.
- **Disarm paths:**
  - `cfg_we` 0x80 (T=0) from IDLE → stays IDLE.
  - `cfg_we` 0x05 while ARMED → IDLE, with no trip after 100 cycles.
  - `cfg_we` 0x8A while ARMED → remaining 10 and pre 0.
- **Reset and saturation:**
  - `rst` at remaining=1 → all outputs at reset values next cycle, with no trip.
  - 260 arm/trip/clear cycles → trip_count holds at 255.
